// File: rtl/edge_event_arbiter_if.sv
// Event handshake port of edge_event_arbiter: the arbiter offers an event
// (valid + channel index) and the shared consumer accepts it with ready.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4
) ();
  localparam int CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;

  modport master (output evt_valid, output evt_ch, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector per line with saturating pending counters, shared
// round-robin among all lines on a single valid/ready event port.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CH-1:0]        din,
  input  logic [N_CH-1:0]        en,
  input  logic [N_CH-1:0]        ovf_clr,
  output logic [N_CH-1:0]        ovf,
  edge_event_arbiter_if.master   evt
);
  localparam int CH_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [N_CH-1:0] prev;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] acc_vec;
  logic [N_CH-1:0] pend, pend_nxt;
  logic [N_CH-1:0] ovf_set;
  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [CH_W-1:0] ptr, ptr_nxt;
  logic [CH_W-1:0] ch_reg, ch_nxt;
  logic [CH_W:0]   pick_idle, pick_acc;
  logic            accept;

  // Search base+1, base+2, ... (mod N_CH); returns {found, index}.
  function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req,
                                            input logic [CH_W-1:0] base);
    logic            found;
    logic [CH_W-1:0] sel;
    int              idx;
    found = 1'b0;
    sel   = base;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(base) + k) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  assign rise          = din & ~prev & en;
  assign evt.evt_valid = (state == S_OFFER);
  assign evt.evt_ch    = ch_reg;
  assign accept        = (state == S_OFFER) && evt.evt_ready;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      acc_vec[i] = accept && (ch_reg == CH_W'(i));
      cnt_nxt[i] = cnt[i];
      ovf_set[i] = 1'b0;
      if (rise[i] && !acc_vec[i]) begin
        if (cnt[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (!rise[i] && acc_vec[i]) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
      pend[i]     = (cnt[i] != '0);
      pend_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  // Idle arbitration sees registered counts; re-arbitration after an accept
  // sees the post-decrement counts so back-to-back events need no idle gap.
  assign pick_idle = rr_pick(pend, ptr);
  assign pick_acc  = rr_pick(pend_nxt, ptr);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ch_nxt    = ch_reg;
    case (state)
      S_IDLE: begin
        if (pick_idle[CH_W]) begin
          state_nxt = S_OFFER;
          ch_nxt    = pick_idle[CH_W-1:0];
          ptr_nxt   = pick_idle[CH_W-1:0];
        end
      end
      S_OFFER: begin
        if (accept) begin
          if (pick_acc[CH_W]) begin
            ch_nxt  = pick_acc[CH_W-1:0];
            ptr_nxt = pick_acc[CH_W-1:0];
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      prev   <= '0;
      ovf    <= '0;
      ptr    <= CH_W'(N_CH - 1);
      ch_reg <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      state  <= state_nxt;
      prev   <= din;
      ovf    <= (ovf & ~ovf_clr) | ovf_set;
      ptr    <= ptr_nxt;
      ch_reg <= ch_nxt;
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected channel indices are queued
// as stimulus is driven and popped whenever the consumer accepts an event.
module tb_edge_event_arbiter;
  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] din, en, ovf_clr, ovf;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  edge_event_arbiter_if #(.N_CH(4)) bus ();

  edge_event_arbiter #(.N_CH(4), .CNT_W(3)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .din     (din),
    .en      (en),
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
    .evt     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.evt_valid) && n < budget) begin
      step();
      n++;
    end
    checkOutput("drain_q", exp_q.size(), 0);
    checkOutput("drain_idle", bus.evt_valid, 0);
  endtask

  // Handshake observed mid-cycle, where it is stable for the next posedge.
  always @(negedge clk) begin
    if (resetn && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) checkOutput("unexpected_evt", {29'd0, 1'b1, bus.evt_ch}, 0);
      else                   checkOutput("evt_ch", bus.evt_ch, exp_q.pop_front());
    end
  end

  initial begin
    resetn        = 1'b0;
    din           = 4'h0;
    en            = 4'hF;
    ovf_clr       = 4'h0;
    bus.evt_ready = 1'b0;

    // T1: reset with toggling lines, then release with din[2] held high
    for (int i = 0; i < 4; i++) begin
      din = (i % 2 == 0) ? 4'hF : 4'h0;
      step();
      checkOutput("rst_valid", bus.evt_valid, 0);
      checkOutput("rst_ovf", ovf, 0);
    end
    din = 4'b0100;
    step();
    exp_q.push_back(2);
    bus.evt_ready = 1'b1;
    resetn = 1'b1;
    drain(20);

    // T2: latency from a single rising edge
    din = 4'h0;
    step();
    step();
    exp_q.push_back(1);
    din = 4'b0010;
    step();
    checkOutput("lat_k_valid", bus.evt_valid, 0);
    step();
    checkOutput("lat_k1_valid", bus.evt_valid, 1);
    checkOutput("lat_k1_ch", bus.evt_ch, 1);
    step();
    checkOutput("lat_k2_valid", bus.evt_valid, 0);
    din = 4'h0;
    drain(20);

    // T3: round-robin with pointer at 3, then at 1
    exp_q.push_back(3);
    din = 4'b1000;
    step();
    din = 4'h0;
    drain(20);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    din = 4'hF;
    step();
    din = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rr_a_valid", bus.evt_valid, 1);
      checkOutput("rr_a_ch", bus.evt_ch, i);
    end
    step();
    checkOutput("rr_a_end", bus.evt_valid, 0);
    exp_q.push_back(1);
    din = 4'b0010;
    step();
    din = 4'h0;
    drain(20);
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    din = 4'hF;
    step();
    din = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rr_b_ch", bus.evt_ch, (i + 2) % 4);
    end
    drain(20);

    // T4: consumer stalls while other channels keep producing edges
    bus.evt_ready = 1'b0;
    din = 4'b0001;
    step();
    din = 4'h0;
    step();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       din = 4'b0010;
        1:       din = 4'b0100;
        2:       din = 4'b0010;
        default: din = 4'b0000;
      endcase
      step();
      checkOutput("hold_valid", bus.evt_valid, 1);
      checkOutput("hold_ch", bus.evt_ch, 0);
    end
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
    bus.evt_ready = 1'b1;
    drain(30);

    // T5: saturation of channel 3, sticky overflow and set-beats-clear
    bus.evt_ready = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      din     = 4'b1000;
      ovf_clr = (n == 9) ? 4'b1000 : 4'b0000;
      step();
      ovf_clr = 4'h0;
      if (n == 7) checkOutput("sat_ovf_n7", ovf[3], 0);
      if (n == 8) checkOutput("sat_ovf_n8", ovf[3], 1);
      if (n == 9) checkOutput("sat_ovf_setwins", ovf[3], 1);
      din = 4'h0;
      if (n == 8) ovf_clr = 4'b1000;
      step();
      ovf_clr = 4'h0;
      if (n == 8) checkOutput("sat_ovf_clr", ovf[3], 0);
    end
    checkOutput("sat_ovf_other", ovf[2:0], 0);
    ovf_clr = 4'b1000;
    step();
    ovf_clr = 4'h0;
    checkOutput("sat_ovf_final_clr", ovf, 0);
    for (int i = 0; i < 7; i++) exp_q.push_back(3);
    bus.evt_ready = 1'b1;
    drain(40);

    // T6a: masked channel keeps its already-pending event
    bus.evt_ready = 1'b0;
    din = 4'b0001;
    step();
    din = 4'h0;
    step();
    en = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      din = 4'b0001;
      step();
      din = 4'h0;
      step();
    end
    exp_q.push_back(0);
    bus.evt_ready = 1'b1;
    drain(30);
    en = 4'hF;

    // T6b: edge and accept on the same channel in the same cycle
    bus.evt_ready = 1'b0;
    din = 4'b0100;
    step();
    din = 4'h0;
    step();
    checkOutput("same_offer_ch", bus.evt_ch, 2);
    exp_q.push_back(2); exp_q.push_back(2);
    din = 4'b0100;
    bus.evt_ready = 1'b1;
    step();
    din = 4'h0;
    checkOutput("same_reoffer", bus.evt_valid, 1);
    drain(30);

    // T6c: asynchronous reset while offering
    bus.evt_ready = 1'b0;
    din = 4'b0010;
    step();
    din = 4'h0;
    step();
    checkOutput("arst_pre_valid", bus.evt_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst_valid", bus.evt_valid, 0);
    step();
    resetn = 1'b1;
    bus.evt_ready = 1'b1;
    repeat (4) step();
    checkOutput("arst_after_valid", bus.evt_valid, 0);

    checkOutput("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
